// File: rtl/serial_word_packer.sv
// -----------------------------------------------------------------------------
// serial_word_packer
//
// Collects a serial bit stream into 16-bit words and presents each complete
// word downstream with a valid/ready handshake. The bit order inside the word
// is set by LSB_FIRST. While a finished word waits for the consumer, further
// bits cannot be stored; they are dropped and flagged on a sticky overrun bit.
//
// States:
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no bits held, waiting for the first bit of a word
//   SHIFT | 1..15 bits of the current word held
//   HOLD  | complete word presented on o_data with o_valid=1
//
// Parameters:
//   LSB_FIRST   1: first received bit lands in bit 0
//               0: first received bit lands in bit 15
//
// Ports:
//   i_clk        system clock, rising-edge active
//   i_rst        asynchronous reset, active high
//   i_bit        serial data bit
//   i_bit_valid  i_bit is valid this cycle
//   i_ready      downstream accepts o_data this cycle
//   o_data       assembled word ([1:0] field select, [13:2] four 3-bit fields)
//   o_valid      o_data holds a complete word
//   o_count      number of bits collected in the current word
//   o_overrun    sticky: a bit arrived while a word was held and was dropped
// -----------------------------------------------------------------------------
module serial_word_packer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bit,
    input  logic        i_bit_valid,
    input  logic        i_ready,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic [3:0]  o_count,
    output logic        o_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] shift_reg;
    logic [15:0] shift_nxt;
    logic [3:0]  bit_pos;

    logic        accept;
    logic        complete;
    logic        hand_off;
    logic        drop;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hand_off  = 1'b0;
        drop      = 1'b0;

        case (state)
            IDLE: begin
                if (i_bit_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (i_bit_valid) begin
                    accept = 1'b1;
                    if (o_count == 4'd15) begin
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                if (i_ready) begin
                    hand_off = 1'b1;
                    // A bit arriving on the hand-off edge starts the next word
                    // immediately, so back-to-back words need no gap cycle.
                    if (i_bit_valid) begin
                        accept    = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (i_bit_valid) begin
                    drop = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // In HOLD o_count is 0, so a bit accepted on the hand-off edge can never
    // be mistaken for the 16th bit.
    assign complete = accept && (o_count == 4'd15);

    // ------------------------------------------------------------------
    // Bit placement
    // ------------------------------------------------------------------
    always_comb begin
        if (LSB_FIRST) begin
            bit_pos = o_count;
        end else begin
            bit_pos = 4'd15 - o_count;
        end
        shift_nxt          = shift_reg;
        shift_nxt[bit_pos] = i_bit;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_reg <= 16'h0000;
            o_data    <= 16'h0000;
            o_valid   <= 1'b0;
            o_count   <= 4'd0;
            o_overrun <= 1'b0;
        end else begin
            if (hand_off) begin
                o_valid <= 1'b0;
            end

            if (accept) begin
                if (complete) begin
                    // The 16th bit goes straight into o_data on the same edge;
                    // the shift register starts clean for the next word.
                    o_data    <= shift_nxt;
                    o_valid   <= 1'b1;
                    o_count   <= 4'd0;
                    shift_reg <= 16'h0000;
                end else begin
                    shift_reg <= shift_nxt;
                    o_count   <= o_count + 4'd1;
                end
            end

            if (drop) begin
                o_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_packer.sv
module tb_serial_word_packer;

    logic        clk;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic        ready;

    logic [15:0] data_l;
    logic        valid_l;
    logic [3:0]  count_l;
    logic        overrun_l;

    logic [15:0] data_m;
    logic        valid_m;
    logic [3:0]  count_m;
    logic        overrun_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_l[$];
    logic [15:0] q_m[$];
    logic        prev_valid_l = 1'b0;
    logic        prev_valid_m = 1'b0;

    serial_word_packer #(.LSB_FIRST(1'b1)) dut_lsb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bit       (bit_in),
        .i_bit_valid (bit_valid),
        .i_ready     (ready),
        .o_data      (data_l),
        .o_valid     (valid_l),
        .o_count     (count_l),
        .o_overrun   (overrun_l)
    );

    serial_word_packer #(.LSB_FIRST(1'b0)) dut_msb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bit       (bit_in),
        .i_bit_valid (bit_valid),
        .i_ready     (ready),
        .o_data      (data_m),
        .o_valid     (valid_m),
        .o_count     (count_m),
        .o_overrun   (overrun_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    // Scoreboard monitor: a word is compared when o_valid rises.
    always @(negedge clk) begin
        if (valid_l && !prev_valid_l) begin
            if (q_l.size() == 0) begin
                check("lsb_unexpected_word", data_l, 16'hxxxx);
            end else begin
                check("lsb_word", data_l, q_l.pop_front());
            end
        end
        if (valid_m && !prev_valid_m) begin
            if (q_m.size() == 0) begin
                check("msb_unexpected_word", data_m, 16'hxxxx);
            end else begin
                check("msb_word", data_m, q_m.pop_front());
            end
        end
        prev_valid_l = valid_l;
        prev_valid_m = valid_m;
    end

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int from, input int upto);
        for (int k = from; k <= upto; k++) send_bit(w[k]);
    endtask

    task automatic expect_word(input logic [15:0] w);
        q_l.push_back(w);
        q_m.push_back(rev16(w));
    endtask

    task automatic handshake();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        ready     = 1'b0;
        #12;
        check("rst_count",   {12'h0, count_l}, 16'h0000);
        check("rst_valid",   {15'h0, valid_l}, 16'h0000);
        check("rst_data",    data_l,           16'h0000);
        check("rst_overrun", {15'h0, overrun_l}, 16'h0000);
        check("rst_data_m",  data_m,           16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic word, both bit orders, held while ready is low.
        q_l.push_back(16'hA5C3);
        q_m.push_back(16'hC3A5);
        w = 16'hA5C3;
        send_bits(w, 0, 14);
        check("cnt_before_last", {12'h0, count_l}, 16'd15);
        check("no_partial_valid", {15'h0, valid_l}, 16'h0000);
        send_bit(w[15]);
        check("a5c3_valid", {15'h0, valid_l}, 16'h0001);
        check("a5c3_count", {12'h0, count_l}, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_data_l",  data_l, 16'hA5C3);
            check("hold_data_m",  data_m, 16'hC3A5);
            check("hold_valid",   {15'h0, valid_l}, 16'h0001);
        end
        handshake();
        check("handoff_valid", {15'h0, valid_l}, 16'h0000);
        check("handoff_data_kept", data_l, 16'hA5C3);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Back-to-back: hand-off edge also carries bit 0 of the next word.
        expect_word(16'h1234);
        w = 16'h1234;
        send_bits(w, 0, 15);
        check("w1234_valid", {15'h0, valid_l}, 16'h0001);
        expect_word(16'hFFFF);
        w = 16'hFFFF;
        ready = 1'b1;
        send_bit(w[0]);
        ready = 1'b0;
        check("b2b_count", {12'h0, count_l}, 16'd1);
        check("b2b_valid", {15'h0, valid_l}, 16'h0000);
        send_bits(w, 1, 15);
        check("ffff_valid",   {15'h0, valid_l}, 16'h0001);
        check("ffff_overrun", {15'h0, overrun_l}, 16'h0000);

        // Overrun: bits arriving while held are dropped.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("ovr_data",    data_l, 16'hFFFF);
        check("ovr_count",   {12'h0, count_l}, 16'h0000);
        check("ovr_flag",    {15'h0, overrun_l}, 16'h0001);
        check("ovr_flag_m",  {15'h0, overrun_m}, 16'h0001);
        handshake();
        check("ovr_sticky",  {15'h0, overrun_l}, 16'h0001);
        check("ovr_valid_cleared", {15'h0, valid_l}, 16'h0000);

        // Reset mid-word, between clock edges.
        w = 16'h01FF;
        send_bits(w, 0, 8);
        check("mid_count", {12'h0, count_l}, 16'd9);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count",   {12'h0, count_l}, 16'h0000);
        check("arst_valid",   {15'h0, valid_l}, 16'h0000);
        check("arst_overrun", {15'h0, overrun_l}, 16'h0000);
        rst = 1'b0;
        expect_word(16'h0006);
        w = 16'h0006;
        send_bits(w, 0, 15);
        check("w0006_data", data_l, 16'h0006);
        check("w0006_data_m", data_m, 16'h6000);
        handshake();

        // Valid toggling every cycle.
        expect_word(16'h5A3C);
        w = 16'h5A3C;
        for (int k = 0; k < 16; k++) begin
            send_bit(w[k]);
            @(posedge clk);
            #1;
            check("toggle_count", {12'h0, count_l}, 16'((k + 1) % 16));
        end
        check("toggle_valid", {15'h0, valid_l}, 16'h0001);
        check("toggle_data", data_l, 16'h5A3C);
        handshake();

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("queue_l_empty", 16'(q_l.size()), 16'h0000);
        check("queue_m_empty", 16'(q_m.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
